dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the shared word-wide data memory. The memory has a combinational read and a synchronous write. Requester 0 is the core load/store path; requester 1 is the debug/DMA path. Each side uses a valid/ready request channel and a valid/ready response channel. The block grants one access at a time with round-robin fairness, drives the memory port, and returns registered read data or a write acknowledge.

---
 rtl/dmem_arbiter_pkg.sv | 14 +
 rtl/dmem_arbiter_rr_arb2.sv | 25 ++
 rtl/dmem_arbiter.sv | 117 +++++++++++
 tb/tb_dmem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: word width, FSM encoding and requester indices.
package dmem_arbiter_pkg;

  localparam int XLEN = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker: a lone requester wins, a tie goes to the one not granted last.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o,
  output logic       idx_o
);

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    idx_o   = REQ_CORE;
    grant_o = 2'b00;
    if (valid_i == 2'b11) begin
      idx_o = ~last_grant_i;
    end else if (valid_i[1]) begin
      idx_o = REQ_DBG;
    end
    if (valid_i != 2'b00) begin
      grant_o = (idx_o == REQ_DBG) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the shared data memory (IDLE accept, RESP hold).
// Optional alignment checking is enabled with `define DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int XLEN   = dmem_arbiter_pkg::XLEN,
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_req_valid,
  output logic [1:0]        o_req_ready,
  input  logic              i_req_wen0,
  input  logic              i_req_wen1,
  input  logic [ADDR_W-1:0] i_req_addr0,
  input  logic [ADDR_W-1:0] i_req_addr1,
  input  logic [XLEN-1:0]   i_req_wd0,
  input  logic [XLEN-1:0]   i_req_wd1,
  output logic [1:0]        o_rsp_valid,
  input  logic [1:0]        i_rsp_ready,
  output logic [XLEN-1:0]   o_rsp_rd,
  output logic              o_rsp_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wd,
  output logic              o_mem_wen,
  input  logic [XLEN-1:0]   i_mem_rd
);

  state_e            state_q;
  logic              last_grant_q;
  logic              owner_q;
  logic [1:0]        rsp_valid_q;
  logic [XLEN-1:0]   rsp_rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wd_q;

  logic [1:0]        grant_oh;
  logic              grant_idx;
  logic              accept;
  logic              unaligned;
  logic              sel_wen;
  logic [ADDR_W-1:0] sel_addr;
  logic [XLEN-1:0]   sel_wd;

  rr_arb2 u_rr_arb2 (
    .valid_i      (i_req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant_oh),
    .idx_o        (grant_idx)
  );

  // Reset gates the accept so ready/wen stay low while i_rst is held, regardless of requests.
  assign accept   = (state_q == ST_IDLE) && (i_req_valid != 2'b00) && !i_rst;
  assign sel_wen  = (grant_idx == REQ_DBG) ? i_req_wen1  : i_req_wen0;
  assign sel_addr = (grant_idx == REQ_DBG) ? i_req_addr1 : i_req_addr0;
  assign sel_wd   = (grant_idx == REQ_DBG) ? i_req_wd1   : i_req_wd0;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic rsp_err_q;
  assign unaligned = (sel_addr[1:0] != 2'b00);
  assign o_rsp_err = rsp_err_q;
`else
  assign unaligned = 1'b0;
  assign o_rsp_err = 1'b0;
`endif

  assign o_req_ready = accept ? grant_oh : 2'b00;
  assign o_mem_wen   = accept && sel_wen && !unaligned;
  assign o_mem_addr  = accept ? sel_addr : addr_q;
  assign o_mem_wd    = accept ? sel_wd   : wd_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rd    = rsp_rd_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= REQ_DBG;
      owner_q      <= REQ_CORE;
      rsp_valid_q  <= 2'b00;
      rsp_rd_q     <= '0;
      addr_q       <= '0;
      wd_q         <= '0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q      <= ST_RESP;
            owner_q      <= grant_idx;
            last_grant_q <= grant_idx;
            rsp_valid_q  <= grant_oh;
            rsp_rd_q     <= (sel_wen || unaligned) ? '0 : i_mem_rd;
            addr_q       <= sel_addr;
            wd_q         <= sel_wd;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            rsp_err_q    <= unaligned;
`endif
          end
        end
        ST_RESP: begin
          // Only the owner's rsp_ready can retire the response.
          if (i_rsp_ready[owner_q]) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 2'b00;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a transaction-level reference model.
module tb_dmem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [1:0]  i_req_valid;
  logic [1:0]  o_req_ready;
  logic        i_req_wen0, i_req_wen1;
  logic [31:0] i_req_addr0, i_req_addr1;
  logic [31:0] i_req_wd0, i_req_wd1;
  logic [1:0]  o_rsp_valid;
  logic [1:0]  i_rsp_ready;
  logic [31:0] o_rsp_rd;
  logic        o_rsp_err;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wd;
  logic        o_mem_wen;
  logic [31:0] i_mem_rd;

  always #5 i_clk = ~i_clk;

  dmem_arbiter #(.XLEN(32), .ADDR_W(32)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_wen0  (i_req_wen0),
    .i_req_wen1  (i_req_wen1),
    .i_req_addr0 (i_req_addr0),
    .i_req_addr1 (i_req_addr1),
    .i_req_wd0   (i_req_wd0),
    .i_req_wd1   (i_req_wd1),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_rd    (o_rsp_rd),
    .o_rsp_err   (o_rsp_err),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wd    (o_mem_wd),
    .o_mem_wen   (o_mem_wen),
    .i_mem_rd    (i_mem_rd)
  );

  function automatic logic [31:0] init_word(int i);
    return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  // Memory attached to the DUT port: combinational read, write on the clock edge.
  logic [31:0] mem [16];
  bit          mem_loaded = 1'b0;
  assign i_mem_rd = mem[o_mem_addr[5:2]];
  always @(posedge i_clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else if (o_mem_wen) begin
      mem[o_mem_addr[5:2]] <= o_mem_wd;
    end
  end

  // Requester drivers: a request stays pending until the model sees it granted.
  logic [1:0]  pend;
  logic        r_wen  [2];
  logic [31:0] r_addr [2];
  logic [31:0] r_wd   [2];
  assign i_req_valid = pend;
  assign i_req_wen0  = r_wen[0];
  assign i_req_wen1  = r_wen[1];
  assign i_req_addr0 = r_addr[0];
  assign i_req_addr1 = r_addr[1];
  assign i_req_wd0   = r_wd[0];
  assign i_req_wd1   = r_wd[1];

  // Reference model: one outstanding transaction, word-addressed memory image.
  logic [31:0] ref_mem [16];
  bit          m_busy;
  int          m_owner;
  int          m_last;
  logic [31:0] m_rd;
  bit          m_err;
  logic [31:0] m_addr;
  bit          m_addr_known;

  logic [1:0]  obs_ready;
  logic [31:0] obs_rd;
  logic        obs_wen;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit unaligned_f(logic [31:0] a);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int pick(logic [1:0] v, int last);
    if (v == 2'b11) return 1 - last;
    return v[1] ? 1 : 0;
  endfunction

  function automatic logic [1:0] onehot(int r);
    return (r == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic reset_model();
    m_busy       = 1'b0;
    m_owner      = 0;
    m_last       = 1;
    m_rd         = '0;
    m_err        = 1'b0;
    m_addr       = '0;
    m_addr_known = 1'b0;
  endtask

  task automatic post(input int r, input bit wen, input logic [31:0] addr, input logic [31:0] wd);
    pend[r]   = 1'b1;
    r_wen[r]  = wen;
    r_addr[r] = addr;
    r_wd[r]   = wd;
  endtask

  // One clock: check outputs at the falling edge, advance the model just after the rising edge.
  task automatic step();
    int  g;
    bit  grant;
    bit  ua;
    @(negedge i_clk);
    obs_ready = o_req_ready;
    obs_rd    = o_rsp_rd;
    obs_wen   = o_mem_wen;
    grant     = !m_busy && (pend != 2'b00);
    g         = pick(pend, m_last);
    ua        = unaligned_f(r_addr[g]);
    if (grant) begin
      check("req_ready", 64'(o_req_ready), 64'(onehot(g)));
      check("mem_wen", 64'(o_mem_wen), 64'(r_wen[g] && !ua));
      check("mem_addr", 64'(o_mem_addr), 64'(r_addr[g]));
      if (r_wen[g]) check("mem_wd", 64'(o_mem_wd), 64'(r_wd[g]));
    end else begin
      check("req_ready_none", 64'(o_req_ready), 64'(0));
      check("mem_wen_none", 64'(o_mem_wen), 64'(0));
      if (m_addr_known) check("mem_addr_hold", 64'(o_mem_addr), 64'(m_addr));
    end
    if (m_busy) begin
      check("rsp_valid", 64'(o_rsp_valid), 64'(onehot(m_owner)));
      check("rsp_rd", 64'(o_rsp_rd), 64'(m_rd));
    end else begin
      check("rsp_valid_none", 64'(o_rsp_valid), 64'(0));
    end
    check("rsp_err", 64'(o_rsp_err), 64'(m_busy ? m_err : 1'b0));
    @(posedge i_clk);
    #1;
    if (grant) begin
      m_rd  = (r_wen[g] || ua) ? 32'h0 : ref_mem[r_addr[g][5:2]];
      if (r_wen[g] && !ua) ref_mem[r_addr[g][5:2]] = r_wd[g];
      m_err        = ua;
      m_busy       = 1'b1;
      m_owner      = g;
      m_last       = g;
      m_addr       = r_addr[g];
      m_addr_known = 1'b1;
      pend[g]      = 1'b0;
    end else if (m_busy && i_rsp_ready[m_owner]) begin
      m_busy = 1'b0;
      m_err  = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] gseq [8];
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    pend        = 2'b00;
    r_wen[0]    = 1'b0; r_wen[1]  = 1'b0;
    r_addr[0]   = '0;   r_addr[1] = '0;
    r_wd[0]     = '0;   r_wd[1]   = '0;
    i_rsp_ready = 2'b11;
    reset_model();

    // Reset: requests pending (including a write) must not leak through.
    i_rst = 1'b1;
    post(0, 1'b1, 32'h10, 32'h1234_5678);
    post(1, 1'b1, 32'h14, 32'h8765_4321);
    #12;
    check("rst_req_ready", 64'(o_req_ready), 64'(0));
    check("rst_rsp_valid", 64'(o_rsp_valid), 64'(0));
    check("rst_rsp_rd", 64'(o_rsp_rd), 64'(0));
    check("rst_rsp_err", 64'(o_rsp_err), 64'(0));
    check("rst_mem_wen", 64'(o_mem_wen), 64'(0));
    pend = 2'b00;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Both requesters reading continuously: core, dbg, core, dbg, one grant every other cycle.
    for (int k = 0; k < 8; k++) begin
      if (!pend[0]) post(0, 1'b0, 32'h0, 32'h0);
      if (!pend[1]) post(1, 1'b0, 32'h4, 32'h0);
      step();
      gseq[k] = obs_ready;
    end
    for (int k = 0; k < 8; k++) begin
      check("alt_grant", 64'(gseq[k]), 64'((k % 2 == 1) ? 2'b00 : ((k % 4 == 0) ? 2'b01 : 2'b10)));
    end
    pend = 2'b00;

    // Core write 0x8 then read it back.
    post(0, 1'b1, 32'h8, 32'hDEAD_BEEF);
    step();
    check("wr_ready", 64'(obs_ready), 64'(2'b01));
    check("wr_wen", 64'(obs_wen), 64'(1));
    step();
    post(0, 1'b0, 32'h8, 32'h0);
    step();
    step();
    check("rd_back", 64'(obs_rd), 64'(32'hDEAD_BEEF));

    // Debug response held off for 5 cycles; core's ready must not retire it.
    i_rsp_ready = 2'b01;
    post(1, 1'b0, 32'h8, 32'h0);
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_no_ready", 64'(obs_ready), 64'(0));
      check("bp_rd_stable", 64'(obs_rd), 64'(32'hDEAD_BEEF));
    end
    i_rsp_ready = 2'b11;
    step();
    step();

    // Debug arrives while core owns the response: granted only after core's handshake.
    i_rsp_ready = 2'b00;
    post(0, 1'b0, 32'hC, 32'h0);
    step();
    post(1, 1'b0, 32'h0, 32'h0);
    step();
    step();
    check("dbg_wait", 64'(obs_ready), 64'(0));
    i_rsp_ready = 2'b01;
    step();
    check("dbg_wait_hs", 64'(obs_ready), 64'(0));
    step();
    check("dbg_after_hs", 64'(obs_ready), 64'(2'b10));
    i_rsp_ready = 2'b11;
    step();

    // Unaligned write to 0x6 and read of 0x4.
    post(0, 1'b1, 32'h6, 32'hCAFE_F00D);
    step();
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    check("ua_wen", 64'(obs_wen), 64'(0));
`else
    check("ua_wen", 64'(obs_wen), 64'(1));
`endif
    step();
    post(0, 1'b0, 32'h4, 32'h0);
    step();
    step();
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    check("ua_old_word", 64'(obs_rd), 64'(init_word(1)));
`else
    check("ua_new_word", 64'(obs_rd), 64'(32'hCAFE_F00D));
`endif

    // Random traffic with random response backpressure.
    for (int n = 0; n < 600; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) == 0)
          post(r, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
      end
      i_rsp_ready = 2'($urandom_range(0, 3));
      step();
    end

    // Reset while a read response is pending.
    pend        = 2'b00;
    i_rsp_ready = 2'b11;
    repeat (3) step();
    post(0, 1'b0, 32'h8, 32'h0);
    step();
    post(1, 1'b0, 32'h0, 32'h0);
    #1;
    i_rst = 1'b1;
    #1;
    check("rst_resp_valid", 64'(o_rsp_valid), 64'(0));
    check("rst_resp_ready", 64'(o_req_ready), 64'(0));
    check("rst_resp_wen", 64'(o_mem_wen), 64'(0));
    reset_model();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    post(0, 1'b0, 32'h4, 32'h0);
    step();
    check("post_rst_grant", 64'(obs_ready), 64'(2'b01));
    pend = 2'b00;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
